tdm_demux: RTL and testbench



---
 rtl/tdm_demux_pkg.sv | 23 ++
 rtl/tdm_demux_slot_counter.sv | 45 ++++
 rtl/tdm_demux.sv | 112 +++++++++++
 tb/tb_tdm_demux.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer.
// Holds the frame-tracking state encodings (as text macros and as a typed
// enum built from them) and the default sample width / channel count.
`ifndef TDM_DEMUX_DEFS
`define TDM_DEMUX_DEFS
`define TDM_HUNT  1'b0
`define TDM_RUN   1'b1
`define TDM_DEF_W 8
`define TDM_DEF_N 4
`endif

package tdm_demux_pkg;

    typedef enum logic {
        ST_HUNT = `TDM_HUNT,
        ST_RUN  = `TDM_RUN
    } state_t;

    localparam int DEF_W  = `TDM_DEF_W;
    localparam int DEF_N  = `TDM_DEF_N;
    localparam int DEF_CW = 2;

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Modulo-N slot counter for the TDM demultiplexer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - force the count to 0
//   i_load1   - load 1 (slot 0 was just accepted)
//   i_inc     - advance by one, wrapping N-1 -> 0
//   o_ch      - registered slot index expected next
//   o_wrap    - o_ch currently points at the last slot (N-1)
module slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_load1,
    input  logic          i_inc,
    output logic [CW-1:0] o_ch,
    output logic          o_wrap
);

    logic [CW-1:0] r_ch;
    logic          w_last;

    assign w_last = (r_ch == CW'(N - 1));

    // clr and load1 are never requested together by the parent; clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch <= '0;
        end else if (i_clr) begin
            r_ch <= '0;
        end else if (i_load1) begin
            r_ch <= CW'(1);
        end else if (i_inc) begin
            r_ch <= w_last ? '0 : r_ch + CW'(1);
        end
    end

    assign o_ch   = r_ch;
    assign o_wrap = w_last;

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: receives a slot-ordered sample stream for N channels,
// tracks slot position from the start-of-frame flag, assembles each frame
// in a shadow bank and publishes completed frames atomically.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   din          - input sample (W bits)
//   din_valid    - din carries a sample this cycle
//   sof          - marks the slot-0 sample (qualified by din_valid)
//   dout         - last complete frame, channel k at [k*W +: W]
//   frame_valid  - one-cycle strobe, dout just updated
//   ch           - slot index expected for the next accepted sample
//   err          - one-cycle pulse on early or missing sof
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           sof,
    output logic [N*W-1:0] dout,
    output logic           frame_valid,
    output logic [CW-1:0]  ch,
    output logic           err
);

    state_t         r_state;
    logic [N*W-1:0] r_shadow;
    logic [N*W-1:0] r_dout;
    logic           r_frame_valid;
    logic           r_err;

    logic [CW-1:0]  w_ch;
    logic           w_wrap;
    logic           w_in_run;
    logic           w_ch_zero;
    logic           w_start;
    logic           w_data;
    logic           w_miss;
    logic           w_early;
    logic           w_done;
    logic           w_write;
    logic [CW-1:0]  w_wr_idx;
    logic [N*W-1:0] w_bank;

    assign w_in_run  = (r_state == ST_RUN);
    assign w_ch_zero = (w_ch == '0);

    // Any accepted sof (re)starts a frame at slot 0, in either state.
    // An early sof additionally flags an error but resyncs immediately.
    assign w_start   = din_valid & sof;
    assign w_early   = w_start & w_in_run & ~w_ch_zero;
    assign w_data    = din_valid & ~sof & w_in_run & ~w_ch_zero;
    assign w_miss    = din_valid & ~sof & w_in_run & w_ch_zero;
    assign w_done    = w_data & w_wrap;
    assign w_write   = w_start | w_data;
    assign w_wr_idx  = sof ? '0 : w_ch;

    // Shadow bank with the incoming sample merged in, so a completing frame
    // can be copied to dout in the same edge that accepts its last sample.
    always_comb begin
        w_bank = r_shadow;
        w_bank[int'(w_wr_idx) * W +: W] = din;
    end

    slot_counter #(
        .N  (N),
        .CW (CW)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_miss),
        .i_load1 (w_start),
        .i_inc   (w_data),
        .o_ch    (w_ch),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_shadow      <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= w_done;
            r_err         <= w_early | w_miss;
            if (w_write) begin
                r_shadow <= w_bank;
            end
            if (w_done) begin
                r_dout <= w_bank;
            end
            case (r_state)
                ST_HUNT: if (w_start) r_state <= ST_RUN;
                ST_RUN:  if (w_miss)  r_state <= ST_HUNT;
                default:              r_state <= ST_HUNT;
            endcase
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign ch          = w_ch;
    assign err         = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

    typedef struct {
        logic        r;
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [1:0]  ech;
        logic        efv;
        logic        eer;
        logic [31:0] edout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        sof;
    logic [31:0] dout;
    logic        frame_valid;
    logic [1:0]  ch;
    logic        err;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sbq[$];
    vec_t        tbl[$];

    tdm_demux #(.W(8), .N(4), .CW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .dout        (dout),
        .frame_valid (frame_valid),
        .ch          (ch),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic [1:0] ech,
                                logic efv, logic eer, logic [31:0] edout);
        vec_t t;
        t.r = 1'b0; t.v = v; t.s = s; t.d = d;
        t.ech = ech; t.efv = efv; t.eer = eer; t.edout = edout;
        return t;
    endfunction

    // Drive one cycle, then compare outputs #1 after the edge. Expected frames
    // go into the scoreboard when their last sample is driven and are popped
    // whenever the DUT raises frame_valid.
    task automatic step(input string nm, input logic r, input logic v, input logic s,
                        input logic [7:0] d, input logic [1:0] ech, input logic efv,
                        input logic eer, input logic [31:0] edout);
        logic [31:0] exp_f;
        rst = r; din_valid = v; sof = s; din = d;
        if (efv) sbq.push_back(edout);
        @(posedge clk);
        #1;
        n_vec++;
        if ({ch, frame_valid, err, dout} !== {ech, efv, eer, edout}) begin
            n_miss++;
            $display("FAIL %s: got ch=%0d fv=%0b err=%0b dout=%h, want ch=%0d fv=%0b err=%0b dout=%h",
                     nm, ch, frame_valid, err, dout, ech, efv, eer, edout);
        end
        if (frame_valid === 1'b1) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_miss++;
                $display("FAIL %s sb: unexpected frame dout=%h, want no frame", nm, dout);
            end else begin
                exp_f = sbq.pop_front();
                if (dout !== exp_f) begin
                    n_miss++;
                    $display("FAIL %s sb: frame dout=%h, want %h", nm, dout, exp_f);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; sof = 1'b0; din = 8'h00;

        // Basic frame, then missing sof, HUNT discard, idle stretch,
        // early sof resync and back-to-back frames.
        tbl.push_back(mk(1, 1, 8'h11, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 8'h22, 2, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 8'h33, 3, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 8'h44, 0, 1, 0, 32'h44332211));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'hAA, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'hBB, 0, 0, 0, 32'h44332211));
        tbl.push_back(mk(0, 1, 8'h99, 0, 0, 0, 32'h44332211));
        tbl.push_back(mk(1, 1, 8'h01, 1, 0, 0, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h02, 2, 0, 0, 32'h44332211));
        tbl.push_back(mk(0, 0, 8'h00, 2, 0, 0, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h03, 3, 0, 0, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h04, 0, 1, 0, 32'h04030201));
        tbl.push_back(mk(1, 1, 8'hA1, 1, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'hA2, 2, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 1, 8'h55, 1, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h66, 2, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h77, 3, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h88, 0, 1, 0, 32'h88776655));
        tbl.push_back(mk(1, 1, 8'hC1, 1, 0, 0, 32'h88776655));
        tbl.push_back(mk(1, 0, 8'hC2, 2, 0, 0, 32'h88776655));
        tbl.push_back(mk(1, 0, 8'hC3, 3, 0, 0, 32'h88776655));
        tbl.push_back(mk(1, 0, 8'hC4, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(1, 1, 8'hD1, 1, 0, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(1, 0, 8'hD2, 2, 0, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(1, 0, 8'hD3, 3, 0, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(1, 0, 8'hD4, 0, 1, 0, 32'hD4D3D2D1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'hD4D3D2D1));

        // Reset and idle.
        step("rst0", 1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
        step("rst1", 1, 1, 1, 8'hEE, 0, 0, 0, 32'h0);
        step("idle0", 0, 0, 0, 8'h00, 0, 0, 0, 32'h0);
        step("idle1", 0, 0, 1, 8'h5A, 0, 0, 0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d,
                 tbl[i].ech, tbl[i].efv, tbl[i].eer, tbl[i].edout);
        end

        // Reset in the middle of a frame, then HUNT drops samples without sof.
        step("mid_e1", 0, 1, 1, 8'hE1, 1, 0, 0, 32'hD4D3D2D1);
        step("mid_e2", 0, 1, 0, 8'hE2, 2, 0, 0, 32'hD4D3D2D1);
        step("mid_rst", 1, 1, 0, 8'hE3, 0, 0, 0, 32'h0);
        step("hunt_aa", 0, 1, 0, 8'hAA, 0, 0, 0, 32'h0);
        step("hunt_bb", 0, 1, 0, 8'hBB, 0, 0, 0, 32'h0);
        step("post_f0", 0, 1, 1, 8'h10, 1, 0, 0, 32'h0);
        step("post_f1", 0, 1, 0, 8'h20, 2, 0, 0, 32'h0);
        step("post_f2", 0, 1, 0, 8'h30, 3, 0, 0, 32'h0);
        step("post_f3", 0, 1, 0, 8'h40, 0, 1, 0, 32'h40302010);
        step("post_idle", 0, 0, 0, 8'h00, 0, 0, 0, 32'h40302010);

        n_vec++;
        if (sbq.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: %0d frames outstanding, want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
